// File: rtl/ysyx_23060184_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port, one outstanding transaction.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with LSU winning ties.
module ysyx_23060184_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  ifu_req,
    input  logic [DATA_WIDTH-1:0] ifu_addr,
    output logic                  ifu_ready,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [DATA_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_wmask,
    output logic                  lsu_ready,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  resp_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_reg, state_next;
    logic                    owner_reg;          // 1 = LSU owns the transaction
    logic [7:0]              tmo_cnt_reg;
    logic                    mem_we_reg;
    logic [DATA_WIDTH-1:0]   mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic [3:0]              mem_wmask_reg;
    logic                    resp_err_reg;
    logic                    rvalid_reg [2];
    logic [DATA_WIDTH-1:0]   rdata_reg  [2];

    logic                    any_req;
    logic                    grant_lsu;
    logic                    grant;
    logic                    tmo_hit;
    logic                    resp_ok;
    logic                    resp_tmo;
    logic                    resp_done;
    logic [DATA_WIDTH-1:0]   resp_data;

    assign any_req = ifu_req | lsu_req;

`ifdef ARB_RR_EN
    logic last_lsu_reg;

    // On a tie, the requester that was not granted last wins.
    assign grant_lsu = lsu_req & (~ifu_req | ~last_lsu_reg);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_lsu_reg <= 1'b1;
        end else if (grant) begin
            last_lsu_reg <= grant_lsu;
        end
    end
`else
    assign grant_lsu = lsu_req;
`endif

    assign tmo_hit   = (tmo_cnt_reg == TMO_LAST);
    assign resp_ok   = ((state_reg == REQ) & mem_ready & mem_rvalid) |
                       ((state_reg == RESP) & mem_rvalid);
    assign resp_tmo  = (state_reg == RESP) & ~mem_rvalid & tmo_hit;
    assign resp_done = resp_ok | resp_tmo;
    assign resp_data = resp_tmo ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (any_req) state_next = REQ;
            REQ: begin
                if (mem_ready) state_next = mem_rvalid ? IDLE : RESP;
            end
            RESP: if (mem_rvalid || tmo_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant     = rstn & (state_reg == IDLE) & any_req;
        ifu_ready = grant & ~grant_lsu;
        lsu_ready = grant & grant_lsu;
        mem_req   = (state_reg == REQ);
    end

    // Request fields are captured at grant; IFU fetches never write.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_reg     <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= 4'h0;
        end else if (grant) begin
            owner_reg     <= grant_lsu;
            mem_we_reg    <= grant_lsu & lsu_we;
            mem_addr_reg  <= grant_lsu ? lsu_addr  : ifu_addr;
            mem_wdata_reg <= grant_lsu ? lsu_wdata : '0;
            mem_wmask_reg <= grant_lsu ? lsu_wmask : 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || state_reg != RESP) begin
            tmo_cnt_reg <= 8'd0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_err_reg <= 1'b0;
        end else begin
            resp_err_reg <= resp_tmo;
        end
    end

    // Index 0 is the IFU response channel, index 1 the LSU channel.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rvalid_reg[gi] <= 1'b0;
                    rdata_reg[gi]  <= '0;
                end else begin
                    rvalid_reg[gi] <= resp_done & (owner_reg == (gi == 1));
                    if (resp_done && (owner_reg == (gi == 1))) begin
                        rdata_reg[gi] <= resp_data;
                    end
                end
            end
        end
    endgenerate

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_wmask  = mem_wmask_reg;
    assign resp_err   = resp_err_reg;
    assign ifu_rvalid = rvalid_reg[0];
    assign ifu_rdata  = rdata_reg[0];
    assign lsu_rvalid = rvalid_reg[1];
    assign lsu_rdata  = rdata_reg[1];

endmodule
